// File: rtl/niosii_system_led_driver.sv
// LED pin driver behind the LED PIO: per-LED pulse stretching and global PWM dimming.
// Everything runs in the PIO clock domain, so pattern_in is used without a synchronizer.
module niosii_system_led_driver #(
   parameter int PRESCALE      = 50,
   parameter int STRETCH_TICKS = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] pattern_in,
   input  logic [3:0] brightness,
   input  logic       enable,
   output logic [7:0] led_out,
   output logic       tick
);

   localparam int             PW        = $clog2(PRESCALE);
   localparam logic [PW-1:0]  PRE_MAX   = PW'(PRESCALE - 1);
   localparam logic [7:0]     HOLD_LOAD = 8'(STRETCH_TICKS);

   logic [7:0]    pat_q;
   logic [7:0]    rise;
   logic [7:0]    lit;
   logic [PW-1:0] pre_cnt;
   logic [3:0]    pwm_cnt;
   logic [7:0]    hold_cnt [8];
   logic          pwm_on;

   assign tick   = (pre_cnt == PRE_MAX);
   assign rise   = pattern_in & ~pat_q;
   assign pwm_on = (brightness == 4'd15) || (pwm_cnt < brightness);

   // An LED is lit while its bit is high or while its stretch counter is still running.
   always_comb begin
      lit = '0;
      for (int i = 0; i < 8; i++) begin
         lit[i] = pat_q[i] | (hold_cnt[i] != 8'd0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q   <= '0;
         pre_cnt <= '0;
         pwm_cnt <= '0;
         led_out <= '0;
         for (int i = 0; i < 8; i++) begin
            hold_cnt[i] <= '0;
         end
      end else begin
         pat_q   <= pattern_in;
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 4'd1;
         end
         // A fresh rising edge wins over a same-cycle tick, so the full stretch is always granted.
         for (int i = 0; i < 8; i++) begin
            if (rise[i]) begin
               hold_cnt[i] <= HOLD_LOAD;
            end else if (tick && (hold_cnt[i] != 8'd0)) begin
               hold_cnt[i] <= hold_cnt[i] - 8'd1;
            end
         end
         led_out <= lit & {8{enable & pwm_on}};
      end
   end

endmodule

// File: tb/tb_niosii_system_led_driver.sv
// Bench for niosii_system_led_driver: edge-count arithmetic model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_niosii_system_led_driver;

   localparam int P = 4;
   localparam int S = 3;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b0;
   logic [7:0] pattern_in = 8'h00;
   logic [3:0] brightness = 4'd15;
   logic       enable     = 1'b1;
   logic [7:0] led_out;
   logic       tick;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   niosii_system_led_driver #(.PRESCALE(P), .STRETCH_TICKS(S)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pattern_in (pattern_in),
      .brightness (brightness),
      .enable     (enable),
      .led_out    (led_out),
      .tick       (tick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_e counts clock edges since reset release. Tick-qualified edges are those with
   // m_e % P == 0, so ticks seen between edges a and b is b/P - a/P.
   int         m_e    = 0;
   logic [7:0] m_pat  = 8'h00;
   int         m_load [8] = '{default: 0};
   logic [7:0] m_loaded = 8'h00;
   logic [7:0] exp_led  = 8'h00;

   function automatic logic [7:0] m_lit(input int m);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         r[i] = m_pat[i] | (m_loaded[i] && ((m / P) - (m_load[i] / P) < S));
      end
      return r;
   endfunction

   function automatic logic m_pwm_on(input int m, input logic [3:0] b);
      int idx;
      idx = (m / P) % 16;
      return (b == 4'd15) || (idx < int'(b));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_e      = 0;
         m_pat    = 8'h00;
         m_loaded = 8'h00;
         exp_led  = 8'h00;
      end else begin
         exp_led = enable ? (m_lit(m_e) & {8{m_pwm_on(m_e, brightness)}}) : 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (pattern_in[i] && !m_pat[i]) begin
               m_load[i]   = m_e + 1;
               m_loaded[i] = 1'b1;
            end
         end
         m_pat = pattern_in;
         m_e++;
      end
   end

   always @(negedge clk) begin
      check("led_out_model", led_out, exp_led);
      check("tick_model", tick, (m_e % P) == (P - 1));
   end

   task automatic wait_tick();
      logic found;
      found = 1'b0;
      for (int k = 0; k < 2 * P; k++) begin
         @(negedge clk);
         if (tick) begin
            found = 1'b1;
            break;
         end
      end
      check("tick_seen", found, 1'b1);
   endtask

   initial begin
      int run;
      int ones;
      int zeros;
      int bad;
      int first;

      // Reset and pass-through
      repeat (3) @(negedge clk);
      check("reset_led", led_out, 8'h00);
      check("reset_tick", tick, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      pattern_in = 8'hA5;
      @(negedge clk);
      check("pass_one_edge", led_out, 8'h00);
      @(negedge clk);
      check("pass_a5", led_out, 8'hA5);
      repeat (16) @(negedge clk);
      pattern_in = 8'h3C;
      @(negedge clk);
      check("pass_old_a5", led_out, 8'hA5);
      @(negedge clk);
      check("pass_3c", led_out, 8'h3C);
      pattern_in = 8'h00;
      repeat (16) @(negedge clk);

      // Pulse stretch over all prescaler phases; phase 0 loads on the tick edge
      for (int ph = 0; ph < P; ph++) begin
         wait_tick();
         repeat (ph) @(negedge clk);
         pattern_in = 8'h01;
         run = 0;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            pattern_in = 8'h00;
            if (led_out[0]) run++;
         end
         check((ph == 0) ? "load_tick_collision" : "stretch_run", run, 12 - ph);
      end

      // Retrigger six cycles after the first pulse
      wait_tick();
      pattern_in = 8'h01;
      run = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (led_out[0]) run++;
         pattern_in = (k == 6) ? 8'h01 : 8'h00;
      end
      check("retrigger_run", run, 16);

      // PWM
      pattern_in = 8'hFF;
      repeat (3) @(negedge clk);
      brightness = 4'd4;
      ones = 0; zeros = 0; bad = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (led_out == 8'hFF) ones++;
         else if (led_out == 8'h00) zeros++;
         else bad++;
      end
      check("pwm4_on", ones, 16);
      check("pwm4_off", zeros, 48);
      check("pwm4_other", bad, 0);
      brightness = 4'd0;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (led_out != 8'h00) bad++;
      end
      check("pwm0_lit", bad, 0);
      brightness = 4'd15;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (led_out != 8'hFF) bad++;
      end
      check("pwm15_dark", bad, 0);

      // Enable masking
      enable = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("enable_masked", led_out, 8'h00);
      end
      enable = 1'b1;
      @(negedge clk);
      check("enable_restored", led_out, 8'hFF);

      // Reset in the middle of a hold
      pattern_in = 8'h00;
      repeat (20) @(negedge clk);
      pattern_in = 8'h01;
      @(negedge clk);
      pattern_in = 8'h00;
      repeat (3) @(negedge clk);
      check("hold_active", led_out[0], 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_async", led_out, 8'h00);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 2 * P; k++) begin
         @(negedge clk);
         if (tick && first < 0) first = k;
      end
      check("first_tick", first, P - 1);
      repeat (12) @(negedge clk);
      check("hold_not_resumed", led_out, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
